m_7seg_sched: RTL and testbench

M_7SEG_SCHED -- requirements
Module: m_7seg_sched

---
 rtl/m_7seg_sched.sv | 134 +++++++++++++
 tb/tb_m_7seg_sched.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/m_7seg_sched.sv
// Round-robin scheduler sharing one 8-digit display among four requesters.
// Optional macro M_7SEG_SCHED_TAG_EN: show the granted index on digit 7.
module m_7seg_sched #(
  parameter int unsigned DWELL = 800000
) (
  input  logic         w_clk,
  input  logic         w_rst_n,
  input  logic [3:0]   w_req,
  input  logic [127:0] w_val,
  input  logic         w_hold,
  output logic [31:0]  r_dout,
  output logic [3:0]   r_gnt,
  output logic [3:0]   r_done,
  output logic         r_busy
);

  typedef enum logic {
    IDLE,
    SHOW
  } state_t;

  localparam logic [31:0] LAST = 32'(DWELL - 1);

  state_t      r_state;
  state_t      s_state_nx;
  logic [1:0]  r_last;
  logic [1:0]  s_last_nx;
  logic [31:0] r_cnt;
  logic [31:0] s_cnt_nx;
  logic [31:0] s_dout_nx;
  logic [3:0]  s_gnt_nx;
  logic [3:0]  s_done_nx;
  logic        s_busy_nx;

  logic        s_win_vld;
  logic [1:0]  s_win_idx;
  logic [1:0]  s_probe;
  logic [31:0] s_sel_val;
  logic [31:0] s_show_val;
  logic        s_rearb;

  // Round-robin search starting just after the last grant
  always_comb begin
    s_win_vld = 1'b0;
    s_win_idx = r_last;
    s_probe   = r_last;
    for (int k = 0; k < 4; k++) begin
      s_probe = s_probe + 2'd1;
      if (!s_win_vld && w_req[s_probe]) begin
        s_win_vld = 1'b1;
        s_win_idx = s_probe;
      end
    end
  end

  // Value of the granted requester, optionally tagged with its index
  always_comb begin
    s_sel_val = w_val[{r_last, 5'd0} +: 32];
`ifdef M_7SEG_SCHED_TAG_EN
    s_show_val = {2'b00, r_last, s_sel_val[27:0]};
`else
    s_show_val = s_sel_val;
`endif
  end

  // Next-state and next-output decode
  always_comb begin
    s_state_nx = r_state;
    s_last_nx  = r_last;
    s_cnt_nx   = r_cnt;
    s_dout_nx  = r_dout;
    s_gnt_nx   = r_gnt;
    s_done_nx  = 4'b0000;
    s_busy_nx  = r_busy;
    s_rearb    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (|w_req)
          s_rearb = 1'b1;
      end
      SHOW: begin
        s_dout_nx = s_show_val;
        if (!w_req[r_last]) begin
          s_rearb = 1'b1;
        end else if (w_hold) begin
          s_cnt_nx = r_cnt;
        end else if (r_cnt == LAST) begin
          s_done_nx[r_last] = 1'b1;
          s_rearb = 1'b1;
        end else begin
          s_cnt_nx = r_cnt + 32'd1;
        end
      end
      default: s_state_nx = IDLE;
    endcase

    if (s_rearb) begin
      s_cnt_nx = 32'd0;
      if (s_win_vld) begin
        s_state_nx = SHOW;
        s_gnt_nx   = 4'b0001 << s_win_idx;
        s_last_nx  = s_win_idx;
        s_busy_nx  = 1'b1;
      end else begin
        s_state_nx = IDLE;
        s_gnt_nx   = 4'b0000;
        s_busy_nx  = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_state <= IDLE;
      r_last  <= 2'd3;
      r_cnt   <= 32'd0;
      r_dout  <= 32'd0;
      r_gnt   <= 4'b0000;
      r_done  <= 4'b0000;
      r_busy  <= 1'b0;
    end else begin
      r_state <= s_state_nx;
      r_last  <= s_last_nx;
      r_cnt   <= s_cnt_nx;
      r_dout  <= s_dout_nx;
      r_gnt   <= s_gnt_nx;
      r_done  <= s_done_nx;
      r_busy  <= s_busy_nx;
    end
  end

endmodule

// File: tb/tb_m_7seg_sched.sv
// Directed bench for the display scheduler.
// Runs with or without M_7SEG_SCHED_TAG_EN.
module tb_m_7seg_sched;

  logic         w_clk = 1'b0;
  logic         w_rst_n;
  logic [3:0]   w_req;
  logic [127:0] w_val;
  logic         w_hold;

  logic [31:0] d4_dout, d3_dout;
  logic [3:0]  d4_gnt, d3_gnt;
  logic [3:0]  d4_done, d3_done;
  logic        d4_busy, d3_busy;

  int checks = 0;
  int errors = 0;
  int ndone  = 0;

  always #5 w_clk = ~w_clk;

  m_7seg_sched #(.DWELL(4)) u_dut (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .w_req(w_req), .w_val(w_val), .w_hold(w_hold),
    .r_dout(d4_dout), .r_gnt(d4_gnt),
    .r_done(d4_done), .r_busy(d4_busy)
  );

  m_7seg_sched #(.DWELL(3)) u_dut3 (
    .w_clk(w_clk), .w_rst_n(w_rst_n),
    .w_req(w_req), .w_val(w_val), .w_hold(w_hold),
    .r_dout(d3_dout), .r_gnt(d3_gnt),
    .r_done(d3_done), .r_busy(d3_busy)
  );

  function automatic logic [31:0] exp_dout(
    input logic [1:0] idx, input logic [31:0] v);
`ifdef M_7SEG_SCHED_TAG_EN
    return {2'b00, idx, v[27:0]};
`else
    return v;
`endif
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge w_clk);
    #1;
  endtask

  initial begin
    logic [3:0] eg;
    logic [3:0] ed;
    w_rst_n = 1'b0;
    w_req   = 4'b0000;
    w_val   = '0;
    w_hold  = 1'b0;
    step(2);

    // reset state
    check("rst_gnt",  32'(d4_gnt), 32'h0);
    check("rst_dout", d4_dout, 32'h0);
    check("rst_done", 32'(d4_done), 32'h0);
    check("rst_busy", 32'(d4_busy), 32'h0);
    check("rst_cnt",  u_dut.r_cnt, 32'h0);
    check("rst_last", 32'(u_dut.r_last), 32'h3);

    // single requester, DWELL=4
    w_rst_n = 1'b1;
    w_val[31:0] = 32'h12345678;
    w_req = 4'b0001;
    step();
    check("a_gnt",  32'(d4_gnt), 32'h1);
    check("a_busy", 32'(d4_busy), 32'h1);
    check("a_dout_hold", d4_dout, 32'h0);
    step();
    check("a_dout", d4_dout, exp_dout(2'd0, 32'h12345678));
    check("a_cnt1", u_dut.r_cnt, 32'd1);
    step(2);
    check("a_nodone", 32'(d4_done), 32'h0);
    check("a_cnt3", u_dut.r_cnt, 32'd3);
    step();
    check("a_done",  32'(d4_done), 32'h1);
    check("a_regnt", 32'(d4_gnt), 32'h1);
    check("a_cnt0",  u_dut.r_cnt, 32'd0);
    w_val[31:0] = 32'hAABBCCDD;
    step();
    check("a_done_1cyc", 32'(d4_done), 32'h0);
    check("a_track", d4_dout, exp_dout(2'd0, 32'hAABBCCDD));

    // all requesting, DWELL=3
    w_rst_n = 1'b0;
    step();
    w_rst_n = 1'b1;
    w_val = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
    w_req = 4'b1111;
    step();
    check("b_gnt0", 32'(d3_gnt), 32'h1);
    for (int g = 0; g < 4; g++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        if (d3_done != 4'b0000) ndone++;
        if (c < 2) begin
          eg = 4'b0001 << g;
          ed = 4'b0000;
        end else begin
          eg = 4'b0001 << ((g + 1) % 4);
          ed = 4'b0001 << g;
        end
        check($sformatf("b_gnt_g%0d_c%0d", g, c), 32'(d3_gnt), 32'(eg));
        check($sformatf("b_done_g%0d_c%0d", g, c), 32'(d3_done), 32'(ed));
      end
    end
    check("b_ndone", ndone, 32'd4);

    // requester 2 drops mid-dwell
    w_rst_n = 1'b0;
    step();
    w_rst_n = 1'b1;
    w_req = 4'b0100;
    step();
    check("c_gnt2", 32'(d4_gnt), 32'h4);
    w_req = 4'b0101;
    step();
    check("c_cnt1", u_dut.r_cnt, 32'd1);
    w_req = 4'b0001;
    step();
    check("c_gnt0", 32'(d4_gnt), 32'h1);
    check("c_nodone", 32'(d4_done), 32'h0);
    check("c_cnt0", u_dut.r_cnt, 32'd0);

    // hold freezes the dwell for 10 cycles
    w_rst_n = 1'b0;
    step();
    w_rst_n = 1'b1;
    w_req = 4'b0001;
    step();
    step();
    check("d_cnt1", u_dut.r_cnt, 32'd1);
    w_hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("d_frozen%0d", i), u_dut.r_cnt, 32'd1);
      check($sformatf("d_nodone%0d", i), 32'(d4_done), 32'h0);
    end
    w_hold = 1'b0;
    step();
    check("d_cnt2", u_dut.r_cnt, 32'd2);
    step();
    check("d_pre", 32'(d4_done), 32'h0);
    step();
    check("d_done", 32'(d4_done), 32'h1);

    // reset mid-SHOW, hold in IDLE is ignored
    w_req = 4'b1111;
    step(2);
    w_rst_n = 1'b0;
    step();
    check("e_gnt",  32'(d4_gnt), 32'h0);
    check("e_dout", d4_dout, 32'h0);
    check("e_done", 32'(d4_done), 32'h0);
    check("e_busy", 32'(d4_busy), 32'h0);
    w_rst_n = 1'b1;
    w_hold = 1'b1;
    step();
    check("e_gnt0", 32'(d4_gnt), 32'h1);
    check("e_busy1", 32'(d4_busy), 32'h1);
    w_hold = 1'b0;

    // requester 3 with all-ones value
    w_rst_n = 1'b0;
    step();
    w_rst_n = 1'b1;
    w_val[127:96] = 32'hFFFFFFFF;
    w_req = 4'b1000;
    step();
    check("f_gnt3", 32'(d4_gnt), 32'h8);
    step();
    check("f_dout", d4_dout, exp_dout(2'd3, 32'hFFFFFFFF));
    w_req = 4'b0000;
    step();
    check("f_idle_gnt", 32'(d4_gnt), 32'h0);
    check("f_idle_busy", 32'(d4_busy), 32'h0);
    step();
    check("f_idle_dout", d4_dout, exp_dout(2'd3, 32'hFFFFFFFF));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
